frame_rx_sm: RTL
================

Name: frame_rx_sm

Overview:
Receive-side frame assembler that pairs with the UART byte receiver and the two-byte frame transmit controller at the far end of the link. It collects two consecutive received bytes (high byte first, then low byte) into a 16-bit command and presents it with a sticky cmd_rdy flag until the consumer clears it. It also acknowledges each byte back to the UART receiver, enforces an inter-byte timeout to resynchronise on lost bytes, and flags overrun when a new command arrives before the previous one is consumed.

Parameters:
TIMEOUT_CYCLES, 65536, maximum number of clk cycles allowed in WAIT_LOW before the partial frame is discarded (must be >= 2)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
rx_rdy  input  1  UART receiver byte-valid level; held high until acknowledged
rx_data  input  8  received byte, valid while rx_rdy=1
clr_rx_rdy  output  1  one-cycle acknowledge to the UART receiver
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy and ovrrun
cmd  output  16  assembled command {high byte, low byte}
cmd_rdy  output  1  sticky; a new command is available on cmd
ovrrun  output  1  sticky; a command was overwritten before it was consumed
to_err  output  1  one-cycle pulse when a partial frame is dropped on timeout

Behaviour:
- Single clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset state: state=IDLE, cmd=16'h0000, cmd_rdy=0, ovrrun=0, clr_rx_rdy=0, to_err=0, timer=0, high-byte register=0.
- Reset mid-frame discards any captured high byte. No acknowledge is issued for a byte pending at reset.
- Byte acceptance: accept = rx_rdy && !clr_rx_rdy. This blocks double acceptance while the UART receiver's rdy is still high during the acknowledge cycle.
- On accept in cycle T, clr_rx_rdy=1 during cycle T+1 only.
- States:
  - IDLE: on accept, capture rx_data into the high-byte register, clear the timer, and go to WAIT_LOW.
  - WAIT_LOW, low byte arrives: on accept, cmd <= {hi, rx_data}, cmd_rdy <= 1 (both visible in T+1), then go to IDLE.
  - WAIT_LOW, no byte: if there is no accept and timer == TIMEOUT_CYCLES-1, go to IDLE, set to_err=1 for one cycle, and leave cmd, cmd_rdy and ovrrun unchanged. Otherwise timer increments by 1.
- Timer:
  - Width is $clog2(TIMEOUT_CYCLES).
  - It counts only in WAIT_LOW and never wraps, because the timeout fires first.
  - Accept and timeout in the same cycle: accept wins and the frame completes.
- cmd_rdy / ovrrun:
  - clr_cmd_rdy=1 with no completion: cmd_rdy <= 0 and ovrrun <= 0.
  - Completion while cmd_rdy=1 and clr_cmd_rdy=0: cmd is overwritten, cmd_rdy stays 1, ovrrun <= 1.
  - Completion and clr_cmd_rdy in the same cycle: cmd_rdy <= 1 and ovrrun <= 0. The set wins, and this is not an overrun.
- Latency: low-byte accept cycle to cmd_rdy high is 1 cycle.
- Minimum spacing is 2 cycles per byte, set by the acknowledge cycle.
- Back-to-back frames are supported with no idle gap beyond the acknowledge cycle.

Decomposition:
- Shared package frame_pkg:
  - state_t enum {IDLE, WAIT_LOW}
  - localparam FRAME_BYTES=2
  - default TIMEOUT_CYCLES constant
  - These are shared with the transmit-side controller for byte-order consistency.
- One natural sub-module, frame_byte_timer: a parameterised counter with clr and en inputs and an expired output. It holds the timeout logic so it can be reused for a transmit-side watchdog.

Test Plan:
- Frame assembly: reset, then bytes 8'hA5 and 8'h3C, each held until clr_rx_rdy.
  - Required: cmd=16'hA53C and cmd_rdy=1 one cycle after the second accept.
  - Required: exactly two clr_rx_rdy pulses, each 1 cycle long.
- Double-accept guard: hold rx_rdy high through the clr_rx_rdy cycle, dropping it the cycle after.
  - Required: only one byte is accepted.
  - Required: state=WAIT_LOW and no second clr_rx_rdy.
- Timeout: TIMEOUT_CYCLES=16; send 8'h11, then nothing for 16 cycles.
  - Required: to_err pulses in the 16th WAIT_LOW cycle, and state returns to IDLE.
  - Then send 8'h22, 8'h33. Required: cmd=16'h2233, with no stale 8'h11.
- Timeout boundary: the low byte's accept cycle coincides with timer == TIMEOUT_CYCLES-1.
  - Required: no to_err pulse, and the frame completes with the correct cmd.
- Overrun: complete frame 16'h0102, do not clear, then complete 16'h0304.
  - Required: cmd=16'h0304, cmd_rdy=1, ovrrun=1.
  - Then clr_cmd_rdy. Required: both flags 0.
- Simultaneous clear, then reset:
  - Assert clr_cmd_rdy in the completion cycle. Required: cmd_rdy=1, ovrrun=0.
  - Assert rst while in WAIT_LOW. Required: state=IDLE and all outputs 0 on the next edge.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame definitions for the receive and transmit frame controllers.
// Byte order on the link is high byte first, then low byte.
package frame_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    localparam int FRAME_BYTES        = 2;
    localparam int CMD_W              = 8 * FRAME_BYTES;
    localparam int TIMEOUT_CYCLES_DEF = 65536;

endpackage

// File: rtl/frame_rx_sm_if.sv
// Byte-side and command-side signals of the receive frame assembler.
// slave is the assembler; master is the UART receiver / command consumer side.
interface frame_rx_sm_if;
    import frame_pkg::*;

    logic             rx_rdy;
    logic [7:0]       rx_data;
    logic             clr_rx_rdy;
    logic             clr_cmd_rdy;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             ovrrun;
    logic             to_err;

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, cmd_rdy, ovrrun, to_err
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd, cmd_rdy, ovrrun, to_err
    );

endinterface

// File: rtl/frame_byte_timer.sv
// Saturating up-counter that flags when CYCLES-1 is reached.
// Shared by the receive inter-byte timeout and the transmit watchdog.
module frame_byte_timer #(
    parameter int CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/frame_rx_sm.sv
// Receive frame assembler: pairs two UART bytes into a 16-bit command.
//   state    | meaning
//   IDLE     | waiting for the high byte of a frame
//   WAIT_LOW | high byte held, waiting for the low byte or the inter-byte timeout
module frame_rx_sm
    import frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    frame_rx_sm_if.slave bus
);

    state_t     state;
    logic [7:0] hi_byte;
    logic       accept;
    logic       complete;
    logic       expired;

    // rx_rdy is still high during the acknowledge cycle, so it must not count twice
    assign accept   = bus.rx_rdy && !bus.clr_rx_rdy;
    assign complete = (state == WAIT_LOW) && accept;

    frame_byte_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      ((state == WAIT_LOW) && !accept),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            hi_byte        <= '0;
            bus.cmd        <= '0;
            bus.cmd_rdy    <= 1'b0;
            bus.ovrrun     <= 1'b0;
            bus.clr_rx_rdy <= 1'b0;
            bus.to_err     <= 1'b0;
        end else begin
            bus.clr_rx_rdy <= accept;
            bus.to_err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        hi_byte <= bus.rx_data;
                        state   <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (accept) begin
                        bus.cmd <= {hi_byte, bus.rx_data};
                        state   <= IDLE;
                    end else if (expired) begin
                        bus.to_err <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh command beats a simultaneous consumer clear and is not an overrun
            if (complete) begin
                bus.cmd_rdy <= 1'b1;
                if (bus.clr_cmd_rdy) begin
                    bus.ovrrun <= 1'b0;
                end else if (bus.cmd_rdy) begin
                    bus.ovrrun <= 1'b1;
                end
            end else if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy <= 1'b0;
                bus.ovrrun  <= 1'b0;
            end
        end
    end

endmodule
